prescaled_counter: RTL and testbench

//  Parametrised LED/event counter driven by an internal cycle prescaler.
//  - Prescaler counts enabled clocks; one count step per CYCLES_PER_TICK enabled clocks.
//  - Adds up/down direction, wrap or saturate mode, synchronous load, tick/wrap pulses.
//  - Used directly on board LEDs (WIDTH=4, 1 s tick at 125 MHz) and as a generic timebase.

---
 rtl/prescaled_counter.sv | 94 +++++++++
 tb/tb_prescaled_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// prescaled_counter: up/down counter with wrap or saturate, stepped once
// per CYCLES_PER_TICK enabled clocks, with registered tick/wrapped pulses.
module prescaled_counter #(
  parameter int WIDTH           = 4,
  parameter int CYCLES_PER_TICK = 125000000,
  parameter int INIT            = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             up,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrapped,
  output logic             at_limit
);

  localparam int PW =
    (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;

  localparam logic [PW-1:0] TERM =
    PW'(CYCLES_PER_TICK - 1);

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             wrapped_q, wrapped_d;

  logic terminal;
  logic at_max;
  logic at_zero;

  // With a single-cycle interval the prescaler sits at 0 == TERM.
  assign terminal = (presc_q == TERM);
  assign at_max   = (count_q == MAX);
  assign at_zero  = (count_q == '0);

  always_comb begin
    count_d   = count_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    wrapped_d = 1'b0;
    if (load) begin
      count_d = load_value;
      presc_d = '0;
    end else if (ce && terminal) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (up) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (!saturate) begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
        end else if (!saturate) begin
          count_d   = MAX;
          wrapped_d = 1'b1;
        end
      end
    end else if (ce) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= INIT_V;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign wrapped  = wrapped_q;
  assign at_limit = up ? at_max : at_zero;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: vector table, corner sequences and random
// stimulus against an arithmetic reference model (CPT=4 and CPT=1).
module tb_prescaled_counter;

  logic       clk = 1'b0;
  logic       rst_n, ce, up, sat, ld;
  logic [3:0] lv;

  logic [3:0] cnt_a, cnt_b;
  logic       tk_a, tk_b, wr_a, wr_b, lim_a, lim_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  prescaled_counter #(
    .WIDTH(4), .CYCLES_PER_TICK(4), .INIT(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .up(up),
    .saturate(sat), .load(ld), .load_value(lv),
    .count(cnt_a), .tick(tk_a), .wrapped(wr_a),
    .at_limit(lim_a)
  );

  prescaled_counter #(
    .WIDTH(4), .CYCLES_PER_TICK(1), .INIT(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .up(up),
    .saturate(sat), .load(ld), .load_value(lv),
    .count(cnt_b), .tick(tk_b), .wrapped(wr_b),
    .at_limit(lim_b)
  );

  typedef struct {
    int cnt;
    int ph;
    bit tk;
    bit wr;
  } mst_t;

  mst_t ma, mb;

  // ph counts enabled clocks since the last step/load/reset.
  function automatic mst_t mnext(
    mst_t s, int cpt, bit rn, bit e, bit u,
    bit st, bit l, int v
  );
    mst_t n;
    int   t;
    n    = s;
    n.tk = 1'b0;
    n.wr = 1'b0;
    if (!rn) begin
      n.cnt = 0;
      n.ph  = 0;
    end else if (l) begin
      n.cnt = v;
      n.ph  = 0;
    end else if (e) begin
      n.ph = s.ph + 1;
      if (n.ph == cpt) begin
        n.ph = 0;
        n.tk = 1'b1;
        t    = u ? s.cnt + 1 : s.cnt - 1;
        if (t < 0 || t > 15) begin
          if (!st) begin
            n.cnt = (t + 16) % 16;
            n.wr  = 1'b1;
          end
        end else begin
          n.cnt = t;
        end
      end
    end
    return n;
  endfunction

  function automatic bit mlim(int c, bit u);
    return u ? (c == 15) : (c == 0);
  endfunction

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    ma = mnext(ma, 4, rst_n, ce, up, sat, ld, int'(lv));
    mb = mnext(mb, 1, rst_n, ce, up, sat, ld, int'(lv));
    @(posedge clk);
    #1;
    chk("a.count", int'(cnt_a), ma.cnt);
    chk("a.tick", int'(tk_a), int'(ma.tk));
    chk("a.wrapped", int'(wr_a), int'(ma.wr));
    chk("a.at_limit", int'(lim_a), int'(mlim(ma.cnt, up)));
    chk("b.count", int'(cnt_b), mb.cnt);
    chk("b.tick", int'(tk_b), int'(mb.tk));
    chk("b.wrapped", int'(wr_b), int'(mb.wr));
    chk("b.at_limit", int'(lim_b), int'(mlim(mb.cnt, up)));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(bit rn, bit e, bit u, bit st,
                        bit l, int v);
    rst_n = rn;
    ce    = e;
    up    = u;
    sat   = st;
    ld    = l;
    lv    = 4'(v);
  endtask

  typedef struct {
    bit rn, e, u, st, l;
    int v;
    int cnt;
    bit tk, wr, lim;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int rep, bit rn, bit e, bit u, bit st,
                     bit l, int v, int c, bit t, bit w,
                     bit lm);
    vec_t r;
    r.rn = rn; r.e = e; r.u = u; r.st = st; r.l = l;
    r.v = v; r.cnt = c; r.tk = t; r.wr = w; r.lim = lm;
    for (int i = 0; i < rep; i++) tbl.push_back(r);
  endtask

  initial begin
    ma = '{0, 0, 1'b0, 1'b0};
    mb = '{0, 0, 1'b0, 1'b0};
    set_in(0, 1, 1, 0, 0, 0);

    // reset, first steps every 4 clocks
    add(2, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    add(3, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0,  1, 1, 0, 0);
    add(3, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0,  2, 1, 0, 0);
    // wrap upward from 14
    add(1, 1, 1, 1, 0, 1, 14, 14, 0, 0, 0);
    add(3, 1, 1, 1, 0, 0, 0,  14, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0,  15, 1, 0, 1);
    add(3, 1, 1, 1, 0, 0, 0,  15, 0, 0, 1);
    add(1, 1, 1, 1, 0, 0, 0,  0, 1, 1, 0);
    // wrap downward from 1
    add(1, 1, 1, 0, 0, 1, 1,  1, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 1);
    add(3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0,  15, 1, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      set_in(tbl[i].rn, tbl[i].e, tbl[i].u, tbl[i].st,
             tbl[i].l, tbl[i].v);
      cyc();
      chk("tbl.count", int'(cnt_a), tbl[i].cnt);
      chk("tbl.tick", int'(tk_a), int'(tbl[i].tk));
      chk("tbl.wrapped", int'(wr_a), int'(tbl[i].wr));
      chk("tbl.at_limit", int'(lim_a), int'(tbl[i].lim));
    end

    // ce alternating: one step per 8 clocks
    set_in(1, 1, 1, 0, 1, 0);
    cyc();
    ld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ce = (i % 2 == 0);
      cyc();
      if (i == 7) chk("gate.8clk", int'(cnt_a), 1);
    end
    chk("gate.16clk", int'(cnt_a), 2);

    // long pause mid-interval keeps prescaler progress
    set_in(1, 1, 1, 0, 1, 5);
    cyc();
    ld = 1'b0;
    run(2);
    ce = 1'b0;
    run(20);
    chk("pause.count", int'(cnt_a), 5);
    chk("pause.tick", int'(tk_a), 0);
    ce = 1'b1;
    run(1);
    chk("resume.hold", int'(cnt_a), 5);
    run(1);
    chk("resume.count", int'(cnt_a), 6);
    chk("resume.tick", int'(tk_a), 1);

    // saturate at max, then reverse
    set_in(1, 1, 1, 1, 1, 14);
    cyc();
    ld = 1'b0;
    run(4);
    chk("sat.first", int'(cnt_a), 15);
    run(4);
    chk("sat.hold", int'(cnt_a), 15);
    chk("sat.tick", int'(tk_a), 1);
    chk("sat.wrapped", int'(wr_a), 0);
    chk("sat.at_limit", int'(lim_a), 1);
    up = 1'b0;
    run(4);
    chk("sat.down", int'(cnt_a), 14);

    // load on a terminal cycle wins
    set_in(1, 1, 1, 0, 1, 8);
    cyc();
    ld = 1'b0;
    run(3);
    ld = 1'b1;
    lv = 4'd9;
    cyc();
    chk("coll.count", int'(cnt_a), 9);
    chk("coll.tick", int'(tk_a), 0);
    ld = 1'b0;
    run(3);
    chk("coll.wait", int'(cnt_a), 9);
    run(1);
    chk("coll.step", int'(cnt_a), 10);
    chk("coll.tick2", int'(tk_a), 1);
    set_in(1, 0, 1, 0, 1, 3);
    cyc();
    chk("load.ce0", int'(cnt_a), 3);

    // reset mid-interval discards progress
    set_in(1, 1, 1, 0, 1, 7);
    cyc();
    ld = 1'b0;
    run(2);
    rst_n = 1'b0;
    cyc();
    chk("rst.count", int'(cnt_a), 0);
    chk("rst.tick", int'(tk_a), 0);
    rst_n = 1'b1;
    run(3);
    chk("rst.wait", int'(cnt_a), 0);
    run(1);
    chk("rst.step", int'(cnt_a), 1);
    chk("cpt1.count", int'(cnt_b), 4);
    chk("cpt1.tick", int'(tk_b), 1);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(63) != 0,
             $urandom_range(3) != 0,
             $urandom_range(7) != 0 ? up : ~up,
             $urandom_range(15) != 0 ? sat : ~sat,
             $urandom_range(15) == 0,
             int'($urandom_range(15)));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
